// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: PC/IF-ID/back-end enables and flushes from debug commands,
// load-use hazards, taken branches and HALT drain. Optional stall counter: PIPELINE_CTRL_STALL_CNT_EN.
module pipeline_ctrl #(
  parameter int NBITS        = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_run,
  input  logic             i_cmd_step,
  input  logic             i_cmd_halt,
  input  logic             i_cmd_clr_cnt,
  input  logic             i_halt_instr,
  input  logic             i_idex_mem_read,
  input  logic [4:0]       i_idex_rt,
  input  logic [4:0]       i_ifid_rs,
  input  logic [4:0]       i_ifid_rt,
  input  logic             i_branch_taken,
  output logic             o_pc_en,
  output logic             o_ifid_en,
  output logic             o_ifid_flush,
  output logic             o_idex_flush,
  output logic             o_back_en,
  output logic             o_halted,
  output logic             o_step_done,
  output logic             o_prog_end,
`ifdef PIPELINE_CTRL_STALL_CNT_EN
  output logic [NBITS-1:0] o_stall_count,
`endif
  output logic [NBITS-1:0] o_cycle_count
);

  localparam int DW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {S_HALTED, S_RUN, S_STEP, S_DRAIN} state_t;

  state_t            r_state, w_next;
  logic [DW-1:0]     r_drain_cnt, w_drain_nxt;
  logic              r_step_done, w_step_done_nxt;
  logic              r_prog_end, w_prog_end_nxt;
  logic [NBITS-1:0]  r_cycle_cnt;
  logic              w_load_use, w_stall, w_active;

  assign w_load_use = i_idex_mem_read & (i_idex_rt != 5'd0) &
                      ((i_idex_rt == i_ifid_rs) | (i_idex_rt == i_ifid_rt));
  assign w_active   = (r_state != S_HALTED);

  always_comb begin
    w_next          = r_state;
    w_drain_nxt     = r_drain_cnt;
    w_step_done_nxt = 1'b0;
    w_prog_end_nxt  = 1'b0;
    w_stall         = 1'b0;
    o_pc_en         = 1'b0;
    o_ifid_en       = 1'b0;
    o_ifid_flush    = 1'b0;
    o_idex_flush    = 1'b0;
    o_back_en       = 1'b0;
    o_halted        = 1'b0;
    case (r_state)
      S_HALTED: begin
        o_halted = 1'b1;
        if (i_cmd_step)     w_next = S_STEP;
        else if (i_cmd_run) w_next = S_RUN;
      end
      S_RUN, S_STEP: begin
        o_pc_en   = 1'b1;
        o_ifid_en = 1'b1;
        o_back_en = 1'b1;
        // A taken branch squashes IF/ID, so the load-use stall is moot then.
        if (w_load_use && !i_branch_taken) begin
          o_pc_en      = 1'b0;
          o_ifid_en    = 1'b0;
          o_idex_flush = 1'b1;
          w_stall      = 1'b1;
        end
        if (i_branch_taken) begin
          o_pc_en      = 1'b1;
          o_ifid_flush = 1'b1;
          o_idex_flush = 1'b1;
        end
        if (r_state == S_RUN && i_cmd_halt) begin
          w_next = S_HALTED;
        end else if (i_halt_instr) begin
          w_next       = S_DRAIN;
          w_drain_nxt  = DRAIN_LOAD;
          o_pc_en      = 1'b0;
          o_ifid_flush = 1'b1;
        end else if (r_state == S_STEP) begin
          w_next          = S_HALTED;
          w_step_done_nxt = 1'b1;
        end
      end
      S_DRAIN: begin
        o_ifid_flush = 1'b1;
        o_back_en    = 1'b1;
        if (i_cmd_halt) begin
          w_next = S_HALTED;
        end else if (r_drain_cnt == '0) begin
          w_next         = S_HALTED;
          w_prog_end_nxt = 1'b1;
        end else begin
          w_drain_nxt = r_drain_cnt - DW'(1);
        end
      end
      default: w_next = S_HALTED;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_HALTED;
      r_drain_cnt <= '0;
      r_step_done <= 1'b0;
      r_prog_end  <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_drain_cnt <= w_drain_nxt;
      r_step_done <= w_step_done_nxt;
      r_prog_end  <= w_prog_end_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                              r_cycle_cnt <= '0;
    else if (i_cmd_clr_cnt)                 r_cycle_cnt <= '0;
    else if (w_active && r_cycle_cnt != '1) r_cycle_cnt <= r_cycle_cnt + NBITS'(1);
  end

`ifdef PIPELINE_CTRL_STALL_CNT_EN
  logic [NBITS-1:0] r_stall_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                             r_stall_cnt <= '0;
    else if (i_cmd_clr_cnt)                r_stall_cnt <= '0;
    else if (w_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + NBITS'(1);
  end

  assign o_stall_count = r_stall_cnt;
`endif

  assign o_step_done   = r_step_done;
  assign o_prog_end    = r_prog_end;
  assign o_cycle_count = r_cycle_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (narrow counter so saturation is reachable).
module tb_pipeline_ctrl;
  localparam int NBITS = 4;

  logic i_clk = 1'b0, i_rst = 1'b1;
  logic i_cmd_run = 0, i_cmd_step = 0, i_cmd_halt = 0, i_cmd_clr_cnt = 0, i_halt_instr = 0;
  logic i_idex_mem_read = 0, i_branch_taken = 0;
  logic [4:0] i_idex_rt = 0, i_ifid_rs = 0, i_ifid_rt = 0;
  logic o_pc_en, o_ifid_en, o_ifid_flush, o_idex_flush, o_back_en, o_halted, o_step_done, o_prog_end;
  logic [NBITS-1:0] o_cycle_count;
`ifdef PIPELINE_CTRL_STALL_CNT_EN
  logic [NBITS-1:0] o_stall_count;
`endif
  logic [5:0] outs;
  int n_tests = 0, n_fail = 0;

  pipeline_ctrl #(.NBITS(NBITS), .DRAIN_CYCLES(3)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cmd_run(i_cmd_run), .i_cmd_step(i_cmd_step),
    .i_cmd_halt(i_cmd_halt), .i_cmd_clr_cnt(i_cmd_clr_cnt), .i_halt_instr(i_halt_instr),
    .i_idex_mem_read(i_idex_mem_read), .i_idex_rt(i_idex_rt), .i_ifid_rs(i_ifid_rs),
    .i_ifid_rt(i_ifid_rt), .i_branch_taken(i_branch_taken), .o_pc_en(o_pc_en),
    .o_ifid_en(o_ifid_en), .o_ifid_flush(o_ifid_flush), .o_idex_flush(o_idex_flush),
    .o_back_en(o_back_en), .o_halted(o_halted), .o_step_done(o_step_done),
    .o_prog_end(o_prog_end),
`ifdef PIPELINE_CTRL_STALL_CNT_EN
    .o_stall_count(o_stall_count),
`endif
    .o_cycle_count(o_cycle_count)
  );

  always #5 i_clk = ~i_clk;
  // {pc_en, ifid_en, ifid_flush, idex_flush, back_en, halted}
  assign outs = {o_pc_en, o_ifid_en, o_ifid_flush, o_idex_flush, o_back_en, o_halted};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_run();
    @(negedge i_clk); i_cmd_run = 1;
    @(negedge i_clk); i_cmd_run = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge i_clk);
    i_rst = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge i_clk); #1;
      n_tests++;
      if (outs !== 6'b000001 || o_cycle_count !== '0 || o_step_done !== 0 || o_prog_end !== 0) begin
        n_fail++;
        $display("FAIL reset_idle cyc%0d: outs=%b cnt=%0d sd=%b pe=%b, want outs=000001 cnt=0 sd=0 pe=0",
                 i, outs, o_cycle_count, o_step_done, o_prog_end);
      end
    end
  endtask

  task automatic test_step();
    for (int k = 0; k < 2; k++) begin
      @(negedge i_clk); i_cmd_clr_cnt = 1;
      @(negedge i_clk); i_cmd_clr_cnt = 0; i_cmd_step = 1; i_cmd_run = (k == 1);
      @(negedge i_clk); i_cmd_step = 0; i_cmd_run = 0; #1;
      n_tests++;
      if (outs !== 6'b110010) begin
        n_fail++; $display("FAIL step_active k%0d: outs=%b want 110010", k, outs);
      end
      @(posedge i_clk); #1;
      n_tests++;
      if (o_halted !== 1 || o_step_done !== 1 || o_cycle_count !== 4'd1) begin
        n_fail++;
        $display("FAIL step_done k%0d: halted=%b sd=%b cnt=%0d want 1 1 1", k, o_halted, o_step_done, o_cycle_count);
      end
      repeat (2) @(posedge i_clk); #1;
      n_tests++;
      if (outs !== 6'b000001 || o_step_done !== 0 || o_cycle_count !== 4'd1) begin
        n_fail++;
        $display("FAIL step_after k%0d: outs=%b sd=%b cnt=%0d want 000001 0 1", k, outs, o_step_done, o_cycle_count);
      end
    end
  endtask

  task automatic test_load_use();
    @(negedge i_clk); i_cmd_clr_cnt = 1;
    @(negedge i_clk); i_cmd_clr_cnt = 0;
    pulse_run();
    i_idex_mem_read = 1; i_idex_rt = 5; i_ifid_rs = 5; i_ifid_rt = 9; #1;
    n_tests++;
    if (outs !== 6'b000110) begin n_fail++; $display("FAIL lu_rs: outs=%b want 000110", outs); end
    @(negedge i_clk); i_idex_rt = 0; i_ifid_rs = 0; i_ifid_rt = 0; #1;
    n_tests++;
    if (outs !== 6'b110010) begin n_fail++; $display("FAIL lu_rt0: outs=%b want 110010", outs); end
`ifdef PIPELINE_CTRL_STALL_CNT_EN
    n_tests++;
    if (o_stall_count !== 4'd1) begin n_fail++; $display("FAIL stall_cnt1: got %0d want 1", o_stall_count); end
`endif
    @(negedge i_clk); i_idex_rt = 7; i_ifid_rs = 3; i_ifid_rt = 7; #1;
    n_tests++;
    if (outs !== 6'b000110) begin n_fail++; $display("FAIL lu_rt: outs=%b want 000110", outs); end
    @(negedge i_clk); i_ifid_rt = 4; #1;
    n_tests++;
    if (outs !== 6'b110010) begin n_fail++; $display("FAIL lu_nomatch: outs=%b want 110010", outs); end
    @(negedge i_clk); i_idex_mem_read = 0; i_ifid_rt = 7; #1;
    n_tests++;
    if (outs !== 6'b110010) begin n_fail++; $display("FAIL lu_noload: outs=%b want 110010", outs); end
  endtask

  task automatic test_branch();
    @(negedge i_clk); i_idex_mem_read = 1; i_idex_rt = 5; i_ifid_rs = 5; i_branch_taken = 1; #1;
    n_tests++;
    if (outs !== 6'b111110) begin n_fail++; $display("FAIL branch_lu: outs=%b want 111110", outs); end
    @(negedge i_clk);
    i_idex_mem_read = 0; i_idex_rt = 0; i_ifid_rs = 0; i_ifid_rt = 0; i_branch_taken = 0;
`ifdef PIPELINE_CTRL_STALL_CNT_EN
    n_tests++;
    if (o_stall_count !== 4'd2) begin n_fail++; $display("FAIL stall_cnt_branch: got %0d want 2", o_stall_count); end
`endif
    i_cmd_halt = 1; #1;
    n_tests++;
    if (outs !== 6'b110010) begin n_fail++; $display("FAIL cmd_halt_adv: outs=%b want 110010", outs); end
    @(posedge i_clk); #1;
    n_tests++;
    if (outs !== 6'b000001) begin n_fail++; $display("FAIL cmd_halt_stop: outs=%b want 000001", outs); end
    @(negedge i_clk); i_cmd_halt = 0;
  endtask

  task automatic test_drain();
    pulse_run();
    i_halt_instr = 1; #1;
    n_tests++;
    if (outs !== 6'b011010) begin n_fail++; $display("FAIL halt_instr: outs=%b want 011010", outs); end
    @(negedge i_clk); i_halt_instr = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (outs !== 6'b001010 || o_prog_end !== 0) begin
        n_fail++; $display("FAIL drain cyc%0d: outs=%b pe=%b want 001010 0", i, outs, o_prog_end);
      end
      @(posedge i_clk); #1;
      n_tests++;
      if (o_prog_end !== (i == 2)) begin
        n_fail++; $display("FAIL prog_end cyc%0d: got %b want %b", i, o_prog_end, (i == 2));
      end
      @(negedge i_clk);
    end
    #1;
    n_tests++;
    if (outs !== 6'b000001) begin n_fail++; $display("FAIL drain_end: outs=%b want 000001", outs); end
    @(posedge i_clk); #1;
    n_tests++;
    if (o_prog_end !== 0) begin n_fail++; $display("FAIL prog_end_once: got %b want 0", o_prog_end); end
    // abort drain with a debug halt
    pulse_run();
    i_halt_instr = 1;
    @(negedge i_clk); i_halt_instr = 0; i_cmd_halt = 1;
    @(posedge i_clk); #1;
    n_tests++;
    if (o_halted !== 1 || o_prog_end !== 0) begin
      n_fail++; $display("FAIL drain_abort: halted=%b pe=%b want 1 0", o_halted, o_prog_end);
    end
    @(negedge i_clk); i_cmd_halt = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk); #1;
      n_tests++;
      if (o_halted !== 1 || o_prog_end !== 0) begin
        n_fail++; $display("FAIL drain_abort_after cyc%0d: halted=%b pe=%b want 1 0", i, o_halted, o_prog_end);
      end
    end
  endtask

  task automatic test_saturate();
    @(negedge i_clk); i_cmd_clr_cnt = 1;
    @(negedge i_clk); i_cmd_clr_cnt = 0;
    pulse_run();
    repeat (14) @(posedge i_clk); #1;
    n_tests++;
    if (o_cycle_count !== 4'd14) begin n_fail++; $display("FAIL cnt_preload: got %0d want 14", o_cycle_count); end
    repeat (3) @(posedge i_clk); #1;
    n_tests++;
    if (o_cycle_count !== 4'd15) begin n_fail++; $display("FAIL cnt_sat: got %0d want 15", o_cycle_count); end
    @(negedge i_clk); i_cmd_clr_cnt = 1;
    @(posedge i_clk); #1;
    n_tests++;
    if (o_cycle_count !== 4'd0) begin n_fail++; $display("FAIL cnt_clr: got %0d want 0", o_cycle_count); end
    @(negedge i_clk); i_cmd_clr_cnt = 0;
    @(posedge i_clk); #1;
    n_tests++;
    if (o_cycle_count !== 4'd1) begin n_fail++; $display("FAIL cnt_after_clr: got %0d want 1", o_cycle_count); end
    @(negedge i_clk); i_cmd_halt = 1;
    @(negedge i_clk); i_cmd_halt = 0;
  endtask

  task automatic test_async_reset();
    pulse_run();
    @(posedge i_clk); #2;
    n_tests++;
    if (outs !== 6'b110010 || o_cycle_count === '0) begin
      n_fail++; $display("FAIL pre_reset_run: outs=%b cnt=%0d want 110010 nonzero", outs, o_cycle_count);
    end
    i_rst = 1; #1;
    n_tests++;
    if (outs !== 6'b000001 || o_cycle_count !== '0 || o_step_done !== 0 || o_prog_end !== 0) begin
      n_fail++; $display("FAIL async_reset: outs=%b cnt=%0d want 000001 0", outs, o_cycle_count);
    end
    @(negedge i_clk); i_rst = 0;
  endtask

  initial begin
    test_reset();
    test_step();
    test_load_use();
    test_branch();
    test_drain();
    test_saturate();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
